// File: rtl/writeback_arbiter.sv
// Writeback arbiter: queues ALU and LSU results in per-source FIFOs, grants one
// head entry per cycle round-robin onto the register-file write port, and tracks pending writes.

module wb_fifo #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_rd,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_rd,
  output logic [DW-1:0] head_data
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;

  // The extra MSB on each pointer separates full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_rd   = rd_mem[rd_ptr[PW-1:0]];
  assign head_data = data_mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        rd_mem[wr_ptr[PW-1:0]]   <= push_rd;
        data_mem[wr_ptr[PW-1:0]] <= push_data;
        wr_ptr                   <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

module writeback_arbiter #(
  parameter int REG_COUNT  = 32,
  parameter int REG_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [$clog2(REG_COUNT)-1:0] alu_rd,
  input  logic [REG_WIDTH-1:0]         alu_data,
  input  logic                         lsu_valid,
  output logic                         lsu_ready,
  input  logic [$clog2(REG_COUNT)-1:0] lsu_rd,
  input  logic [REG_WIDTH-1:0]         lsu_data,
  input  logic                         issue_valid,
  input  logic [$clog2(REG_COUNT)-1:0] issue_rd,
  output logic [$clog2(REG_COUNT)-1:0] rf_address,
  output logic [REG_WIDTH-1:0]         rf_wr_data,
  output logic                         rf_wr_en,
  output logic [REG_COUNT-1:0]         pending
);
  localparam int AW = $clog2(REG_COUNT);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_t;

  src_t rr_state, rr_next;
  src_t grant_src;
  logic grant_valid;

  logic          alu_full, alu_empty, alu_push, alu_pop;
  logic          lsu_full, lsu_empty, lsu_push, lsu_pop;
  logic [AW-1:0] alu_head_rd, lsu_head_rd, grant_rd;
  logic [REG_WIDTH-1:0] alu_head_data, lsu_head_data, grant_data;

  logic [REG_COUNT-1:0] set_vec, clr_vec, pending_next;

  assign alu_ready = !alu_full && !reset;
  assign lsu_ready = !lsu_full && !reset;

  // Writes to r0 finish the handshake but never occupy a slot.
  assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign lsu_push = lsu_valid && lsu_ready && (lsu_rd != '0);

  wb_fifo #(.AW(AW), .DW(REG_WIDTH), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (alu_push),
    .push_rd   (alu_rd),
    .push_data (alu_data),
    .pop       (alu_pop),
    .full      (alu_full),
    .empty     (alu_empty),
    .head_rd   (alu_head_rd),
    .head_data (alu_head_data)
  );

  wb_fifo #(.AW(AW), .DW(REG_WIDTH), .DEPTH(FIFO_DEPTH)) u_lsu_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (lsu_push),
    .push_rd   (lsu_rd),
    .push_data (lsu_data),
    .pop       (lsu_pop),
    .full      (lsu_full),
    .empty     (lsu_empty),
    .head_rd   (lsu_head_rd),
    .head_data (lsu_head_data)
  );

  always_ff @(posedge clk) begin
    if (reset) rr_state <= SRC_ALU;
    else       rr_state <= rr_next;
  end

  // The priority pointer only moves when both sources compete.
  always_comb begin
    rr_next     = rr_state;
    grant_valid = !alu_empty || !lsu_empty;
    grant_src   = SRC_ALU;
    if (!alu_empty && !lsu_empty) begin
      grant_src = rr_state;
      rr_next   = (rr_state == SRC_ALU) ? SRC_LSU : SRC_ALU;
    end else if (!lsu_empty) begin
      grant_src = SRC_LSU;
    end
  end

  assign alu_pop    = grant_valid && (grant_src == SRC_ALU);
  assign lsu_pop    = grant_valid && (grant_src == SRC_LSU);
  assign grant_rd   = (grant_src == SRC_ALU) ? alu_head_rd   : lsu_head_rd;
  assign grant_data = (grant_src == SRC_ALU) ? alu_head_data : lsu_head_data;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && (issue_rd != '0)) set_vec[issue_rd] = 1'b1;
    if (grant_valid) clr_vec[grant_rd] = 1'b1;
    // A new reservation landing on the retiring register must survive.
    pending_next    = (pending & ~clr_vec) | set_vec;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr_en   <= 1'b0;
      rf_address <= '0;
      rf_wr_data <= '0;
      pending    <= '0;
    end else begin
      rf_wr_en <= grant_valid;
      if (grant_valid) begin
        rf_address <= grant_rd;
        rf_wr_data <= grant_data;
      end
      pending <= pending_next;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized bench for writeback_arbiter: a queue-based reference model predicts
// readiness, pending bits and the register-file write stream; a monitor compares each cycle.

module tb_writeback_arbiter;
  localparam int REG_COUNT  = 32;
  localparam int REG_WIDTH  = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int AW         = $clog2(REG_COUNT);

  typedef struct {
    logic [AW-1:0]        rd;
    logic [REG_WIDTH-1:0] data;
  } ent_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 alu_valid, alu_ready;
  logic [AW-1:0]        alu_rd;
  logic [REG_WIDTH-1:0] alu_data;
  logic                 lsu_valid, lsu_ready;
  logic [AW-1:0]        lsu_rd;
  logic [REG_WIDTH-1:0] lsu_data;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic [AW-1:0]        rf_address;
  logic [REG_WIDTH-1:0] rf_wr_data;
  logic                 rf_wr_en;
  logic [REG_COUNT-1:0] pending;

  writeback_arbiter #(.REG_COUNT(REG_COUNT), .REG_WIDTH(REG_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rf_address  (rf_address),
    .rf_wr_data  (rf_wr_data),
    .rf_wr_en    (rf_wr_en),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  // Reference model: plain queues per source, a priority flag, a pending bitmap.
  ent_t                 m_alu[$];
  ent_t                 m_lsu[$];
  ent_t                 exp_wr[$];
  bit                   m_rr_lsu = 1'b0;
  logic [REG_COUNT-1:0] m_pend   = '0;
  logic [AW-1:0]        m_addr   = '0;
  logic [REG_WIDTH-1:0] m_data   = '0;

  int n_vec = 0;
  int n_err = 0;
  int n_full_seen = 0;

  always @(posedge clk) begin
    bit   acc_a, acc_l, has_g;
    ent_t g, e;
    if (reset) begin
      m_alu.delete();
      m_lsu.delete();
      exp_wr.delete();
      m_rr_lsu = 1'b0;
      m_pend   = '0;
      m_addr   = '0;
      m_data   = '0;
    end else begin
      acc_a = alu_valid && (m_alu.size() < FIFO_DEPTH);
      acc_l = lsu_valid && (m_lsu.size() < FIFO_DEPTH);
      has_g = 1'b0;
      if (m_alu.size() > 0 && m_lsu.size() > 0) begin
        if (m_rr_lsu) g = m_lsu.pop_front();
        else          g = m_alu.pop_front();
        m_rr_lsu = !m_rr_lsu;
        has_g = 1'b1;
      end else if (m_alu.size() > 0) begin
        g = m_alu.pop_front();
        has_g = 1'b1;
      end else if (m_lsu.size() > 0) begin
        g = m_lsu.pop_front();
        has_g = 1'b1;
      end
      if (has_g) begin
        m_pend[g.rd] = 1'b0;
        m_addr = g.rd;
        m_data = g.data;
        exp_wr.push_back(g);
      end
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      m_pend[0] = 1'b0;
      if (acc_a && alu_rd != 0) begin
        e.rd = alu_rd; e.data = alu_data; m_alu.push_back(e);
      end
      if (acc_l && lsu_rd != 0) begin
        e.rd = lsu_rd; e.data = lsu_data; m_lsu.push_back(e);
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: called at the falling edge, before the inputs move.
  task automatic check_cycle();
    ent_t w;
    bit   exp_ra, exp_rl, exp_en;
    exp_ra = !reset && (m_alu.size() < FIFO_DEPTH);
    exp_rl = !reset && (m_lsu.size() < FIFO_DEPTH);
    if (!reset && !exp_ra) n_full_seen++;
    cmp("alu_ready", 64'(alu_ready), 64'(exp_ra));
    cmp("lsu_ready", 64'(lsu_ready), 64'(exp_rl));
    cmp("pending", 64'(pending), 64'(m_pend));
    exp_en = (exp_wr.size() > 0);
    cmp("rf_wr_en", 64'(rf_wr_en), 64'(exp_en));
    if (exp_en) begin
      w = exp_wr.pop_front();
      if (rf_wr_en) begin
        cmp("wr_address", 64'(rf_address), 64'(w.rd));
        cmp("wr_data", 64'(rf_wr_data), 64'(w.data));
      end
    end else begin
      cmp("hold_address", 64'(rf_address), 64'(m_addr));
      cmp("hold_data", 64'(rf_wr_data), 64'(m_data));
    end
  endtask

  task automatic drive(input int pa, input int pl, input int pi, input int pr);
    reset       = ($urandom_range(0, 999) < pr);
    alu_valid   = ($urandom_range(0, 99) < pa);
    lsu_valid   = ($urandom_range(0, 99) < pl);
    issue_valid = ($urandom_range(0, 99) < pi);
    alu_rd      = AW'($urandom_range(0, 15));
    lsu_rd      = AW'($urandom_range(0, 15));
    issue_rd    = AW'($urandom_range(0, 15));
    alu_data    = $urandom;
    lsu_data    = $urandom;
  endtask

  task automatic idle();
    reset = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
    alu_rd = '0; lsu_rd = '0; issue_rd = '0; alu_data = '0; lsu_data = '0;
    repeat (3) step();
    idle();

    // Single ALU write, then a reservation followed by the matching write.
    step();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    step();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
    step();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
    step();
    idle();
    repeat (5) step();

    // Random phases: light, heavy, full flood, with resets, LSU-skewed.
    for (int i = 0; i < 300; i++) begin drive(30, 30, 20, 0);   step(); end
    for (int i = 0; i < 300; i++) begin drive(90, 90, 50, 0);   step(); end
    for (int i = 0; i < 300; i++) begin drive(100, 100, 30, 0); step(); end
    for (int i = 0; i < 300; i++) begin drive(60, 40, 40, 20);  step(); end
    for (int i = 0; i < 300; i++) begin drive(20, 80, 40, 0);   step(); end

    idle();
    repeat (20) step();
    cmp("full_reached", 64'(n_full_seen > 0), 64'd1);
    cmp("drained", 64'(m_alu.size() + m_lsu.size() + exp_wr.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
